// File: rtl/mem_pkg.sv
// Shared definitions for mem_responder: size encodings, FSM states and
// lane-placement helpers for right-aligned write data.
`include "common.svh"

package mem_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Size 3 falls through to the word case.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      MEM_B:   return 4'b0001 << ofs;
      MEM_H:   return ofs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size,
                                            input logic [`DATA_WIDTH-1:0] d);
    case (size)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d[31:0];
    endcase
  endfunction

endpackage

// File: rtl/common.svh
// Shared build-wide macros for the memory responder slice.
`ifndef COMMON_SVH
`define COMMON_SVH
`define DATA_WIDTH 32
`endif

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM, DEPTH 32-bit words with per-byte write enables.
// Contents are not reset.
module mem_resp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Latency-configurable memory responder (IDLE/WAIT/RESP) over mem_resp_ram.
// Define MEM_RESP_BOUNDS_EN to add o_err and out-of-range request dropping.
`include "common.svh"

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_addr,
  input  logic [`DATA_WIDTH-1:0] i_data,
  input  logic [1:0]             i_size,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic                   i_rd_ready,
  output logic                   o_rd_valid,
  output logic [`DATA_WIDTH-1:0] o_data,
  output logic                   o_busy
`ifdef MEM_RESP_BOUNDS_EN
  ,
  output logic                   o_err
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [1:0]             ofs_q, ofs_d;
  logic [`DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]             size_q, size_d;
  logic                   wr_q, wr_d;
  logic                   oob;

  logic          ram_we, ram_re;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

`ifdef MEM_RESP_BOUNDS_EN
  logic oob_q, oob_d, oob_cap;
  assign oob_cap = 64'(i_addr) >= (64'(DEPTH) * 64'd4);
  assign oob     = oob_q;
`else
  // Upper address bits only matter when range checking is built in.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:AW+2];
  assign oob            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ofs_d   = ofs_q;
    data_d  = data_q;
    size_d  = size_q;
    wr_d    = wr_q;
    ram_re  = 1'b0;
`ifdef MEM_RESP_BOUNDS_EN
    oob_d   = oob_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_wr_valid || i_rd_ready) begin
          wr_d   = i_wr_valid;
          idx_d  = i_addr[AW+1:2];
          ofs_d  = i_addr[1:0];
          data_d = i_data;
          size_d = i_size;
          cnt_d  = LAT;
`ifdef MEM_RESP_BOUNDS_EN
          oob_d  = oob_cap;
`endif
          // Zero latency skips WAIT, so the RAM read happens on the capture edge.
          if (LAT == '0) begin
            state_d = ST_RESP;
            ram_re  = !i_wr_valid;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!(wr_q ? i_wr_valid : i_rd_ready)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d = ST_RESP;
            ram_re  = !wr_q;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ofs_q   <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
`ifdef MEM_RESP_BOUNDS_EN
      oob_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ofs_q   <= ofs_d;
      data_q  <= data_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
`ifdef MEM_RESP_BOUNDS_EN
      oob_q   <= oob_d;
`endif
    end
  end

  assign ram_addr  = (state_q == ST_IDLE) ? i_addr[AW+1:2] : idx_q;
  assign ram_we    = (state_q == ST_RESP) && wr_q && !oob;
  assign ram_be    = lane_be(size_q, ofs_q);
  assign ram_wdata = lane_data(size_q, data_q);

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign o_wr_ready = (state_q == ST_RESP) && wr_q;
  assign o_rd_valid = (state_q == ST_RESP) && !wr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_data     = (o_rd_valid && !oob) ? (ram_rdata >> {ofs_q, 3'b000}) : '0;
`ifdef MEM_RESP_BOUNDS_EN
  assign o_err      = (state_q == ST_RESP) && oob_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, corner-case
// sequences, and random traffic against a byte-addressed reference model.
`include "common.svh"

module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned BYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst;

  logic [31:0]            addr;
  logic [`DATA_WIDTH-1:0] wdata;
  logic [1:0]             size;
  logic                   wr_valid, rd_ready, wr_ready, rd_valid, busy;
  logic [`DATA_WIDTH-1:0] rdata;

  logic [31:0]            a0_addr;
  logic [`DATA_WIDTH-1:0] a0_wdata;
  logic [1:0]             a0_size;
  logic                   a0_wr_valid, a0_rd_ready, a0_wr_ready, a0_rd_valid, a0_busy;
  logic [`DATA_WIDTH-1:0] a0_rdata;

`ifdef MEM_RESP_BOUNDS_EN
  logic err, a0_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  mem_b [BYTES];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_data(wdata), .i_size(size),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_rd_ready(rd_ready),
    .o_rd_valid(rd_valid), .o_data(rdata), .o_busy(busy)
`ifdef MEM_RESP_BOUNDS_EN
    , .o_err(err)
`endif
  );

  mem_responder #(.DEPTH(16), .LATENCY(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_addr(a0_addr), .i_data(a0_wdata), .i_size(a0_size),
    .i_wr_valid(a0_wr_valid), .o_wr_ready(a0_wr_ready), .i_rd_ready(a0_rd_ready),
    .o_rd_valid(a0_rd_valid), .o_data(a0_rdata), .o_busy(a0_busy)
`ifdef MEM_RESP_BOUNDS_EN
    , .o_err(a0_err)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_RESP_BOUNDS_EN
    return 64'(a) >= 64'(BYTES);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: flat byte memory; sizes pick an aligned group of bytes.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int unsigned base, n, off;
    if (is_oob(a)) return;
    off = a % BYTES;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = off - (off % n);
    for (int unsigned k = 0; k < n; k++) mem_b[base + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned off;
    logic [31:0] r;
    r = '0;
    if (is_oob(a)) return r;
    off = a % BYTES;
    for (int unsigned k = 0; k < 4 - (off % 4); k++) r = r | (32'(mem_b[off + k]) << (8*k));
    return r;
  endfunction

  // Starts and ends on a falling edge; the DUT is idle again on return.
  task automatic run_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input string tag,
                            input logic [31:0] exp_data, input logic exp_err);
    int unsigned n;
    bit seen;
    addr = a; wdata = d; size = sz; wr_valid = wr; rd_ready = !wr;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (wr_ready || rd_valid) seen = 1;
      else check({tag, " data-idle"}, rdata, 32'h0);
    end
    check({tag, " latency"}, n, LAT + 1);
    check({tag, " pulse"}, {30'b0, wr_ready, rd_valid}, wr ? 32'd2 : 32'd1);
    if (!wr) check({tag, " rdata"}, rdata, exp_data);
`ifdef MEM_RESP_BOUNDS_EN
    check({tag, " err"}, err, exp_err);
`else
    if (exp_err) check({tag, " unexpected err expectation"}, 32'd1, 32'd0);
`endif
    wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    check({tag, " busy-after"}, busy, 1'b0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int unsigned n;
    bit          seen;
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    logic        rw;

    rst = 1; addr = '0; wdata = '0; size = '0; wr_valid = 0; rd_ready = 0;
    a0_addr = '0; a0_wdata = '0; a0_size = '0; a0_wr_valid = 0; a0_rd_ready = 0;
    for (int unsigned i = 0; i < BYTES; i++) mem_b[i] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst wr_ready", wr_ready, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst busy", busy, 0);
    check("rst data", rdata, 0);
    check("rst0 busy", a0_busy, 0);
    rst = 0;
    @(negedge clk);

    for (int unsigned w = 0; w < 16; w++) run_access(1, 4*w, 32'h0, 2'd2, "clear", 0, 0);

    vecs.push_back('{1, 32'h10, 32'hDEADBEEF, 2'd2, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0,        2'd2, 32'hDEADBEEF});
    vecs.push_back('{1, 32'h13, 32'h000000AB, 2'd0, 32'h0});
    vecs.push_back('{0, 32'h13, 32'h0,        2'd0, 32'h000000AB});
    vecs.push_back('{0, 32'h10, 32'h0,        2'd2, 32'hABADBEEF});
    vecs.push_back('{0, 32'h12, 32'h0,        2'd1, 32'h0000ABAD});
    vecs.push_back('{0, 32'h10, 32'h0,        2'd3, 32'hABADBEEF});
    vecs.push_back('{1, 32'h11, 32'hFFFF1234, 2'd1, 32'h0});
    vecs.push_back('{0, 32'h10, 32'h0,        2'd2, 32'hABAD1234});
    vecs.push_back('{1, 32'h17, 32'h01020304, 2'd3, 32'h0});
    vecs.push_back('{0, 32'h14, 32'h0,        2'd2, 32'h01020304});
    vecs.push_back('{0, 32'h15, 32'h0,        2'd0, 32'h00010203});
`ifdef MEM_RESP_BOUNDS_EN
    vecs.push_back('{1, 32'h1010, 32'h55667788, 2'd2, 32'h0});
    vecs.push_back('{0, 32'h1000, 32'h0,        2'd2, 32'h0});
    vecs.push_back('{0, 32'h10,   32'h0,        2'd2, 32'hABAD1234});
`else
    vecs.push_back('{1, 32'h1010, 32'h55667788, 2'd2, 32'h0});
    vecs.push_back('{0, 32'h10,   32'h0,        2'd2, 32'h55667788});
`endif
    foreach (vecs[i]) begin
      run_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].size,
                 $sformatf("vec%0d", i), vecs[i].exp, is_oob(vecs[i].addr));
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].data, vecs[i].size);
    end

    // Write dropped while waiting: no pulse, memory untouched.
    addr = 32'h10; wdata = 32'hFFFFFFFF; size = 2'd2; wr_valid = 1;
    @(negedge clk);
    check("abort busy", busy, 1);
    wr_valid = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_ready || rd_valid) seen = 1;
    end
    check("abort no pulse", seen, 0);
    check("abort idle", busy, 0);
    run_access(0, 32'h10, 0, 2'd2, "abort readback", model_read(32'h10), 0);

    // Asynchronous reset in WAIT of a read.
    addr = 32'h10; size = 2'd2; rd_ready = 1;
    @(negedge clk);
    check("rstwait busy", busy, 1);
    rst = 1;
    #1;
    check("rstwait busy async", busy, 0);
    check("rstwait rd_valid", rd_valid, 0);
    check("rstwait data", rdata, 0);
    rd_ready = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset in the RESP cycle of a write discards it.
    addr = 32'h10; wdata = 32'h77777777; size = 2'd2; wr_valid = 1;
    repeat (3) @(negedge clk);
    check("rstresp pulse", wr_ready, 1);
    rst = 1;
    #1;
    check("rstresp wr_ready async", wr_ready, 0);
    check("rstresp busy async", busy, 0);
    wr_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_access(0, 32'h10, 0, 2'd2, "rstresp readback", model_read(32'h10), 0);

    // Both requests together: write first, read follows back-to-back.
    addr = 32'h20; wdata = 32'h0BADF00D; size = 2'd2; wr_valid = 1; rd_ready = 1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(negedge clk); n++; seen = wr_ready || rd_valid; end
    check("both wr latency", n, LAT + 1);
    check("both wr first", {wr_ready, rd_valid}, 2'b10);
    model_write(32'h20, 32'h0BADF00D, 2'd2);
    wr_valid = 0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin @(negedge clk); n++; seen = wr_ready || rd_valid; end
    check("both rd gap", n, LAT + 2);
    check("both rd pulse", {wr_ready, rd_valid}, 2'b01);
    check("both rd data", rdata, model_read(32'h20));
    rd_ready = 0;
    @(negedge clk);

    // Zero-latency instance: pulse on the cycle after capture.
    a0_addr = 32'h4; a0_wdata = 32'hCAFEF00D; a0_size = 2'd2; a0_wr_valid = 1;
    @(negedge clk);
    check("L0 wr pulse", a0_wr_ready, 1);
    check("L0 busy", a0_busy, 1);
    a0_wr_valid = 0;
    @(negedge clk);
    check("L0 wr done", a0_wr_ready, 0);
    a0_rd_ready = 1;
    @(negedge clk);
    check("L0 rd pulse", a0_rd_valid, 1);
    check("L0 rd data", a0_rdata, 32'hCAFEF00D);
    a0_rd_ready = 0;
    @(negedge clk);
    a0_addr = 32'h6; a0_size = 2'd0; a0_rd_ready = 1;
    @(negedge clk);
    check("L0 rd byte data", a0_rdata, 32'h0000CAFE);
    a0_rd_ready = 0;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? BYTES + $urandom_range(0, 63) : $urandom_range(0, 63);
      rd = $urandom;
      rs = 2'($urandom_range(0, 3));
      run_access(rw, ra, rd, rs, $sformatf("rnd%0d", i), model_read(ra), is_oob(ra));
      if (rw) model_write(ra, rd, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, extra wait cycles per access (legal range 0..15).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_addr  input  32  byte address of the request.
REQ-006 SHALL have port i_data  input  `DATA_WIDTH  write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port i_size  input  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-008 SHALL have port i_wr_valid  input  1  write request, held until o_wr_ready.
REQ-009 SHALL have port o_wr_ready  output  1  one-cycle pulse completing a write.
REQ-010 SHALL have port i_rd_ready  input  1  read request, held until o_rd_valid.
REQ-011 SHALL have port o_rd_valid  output  1  one-cycle pulse completing a read.
REQ-012 SHALL have port o_data  output  `DATA_WIDTH  read data; valid only while o_rd_valid=1, 0 otherwise.
REQ-013 SHALL have port o_busy  output  1  high in WAIT and RESP.
REQ-014 SHALL have port o_err  output  1  range-error pulse, present only with MEM_RESP_BOUNDS_EN.

Function
REQ-015 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-016 SHALL, in IDLE with a request present, capture addr/data/size/direction and go to WAIT with the counter loaded to LATENCY.
REQ-017 SHALL give i_wr_valid priority when both requests are high in IDLE; the read stays pending and is served next.
REQ-018 SHALL, in WAIT, decrement the counter and move to RESP when it is 0; with LATENCY=0, RESP follows the capture cycle directly.
REQ-019 SHALL assert o_wr_ready or o_rd_valid for exactly the RESP cycle, then return to IDLE; a capture-to-pulse distance is LATENCY+1 cycles.
REQ-020 SHALL sample a new request in IDLE on the cycle after RESP, with no minimum gap beyond that.
REQ-021 SHALL abort to IDLE with no response and no memory write if the captured request drops in WAIT.
REQ-022 SHALL ignore changes to addr/data/size after capture.
REQ-023 SHALL index the word as addr[log2(DEPTH)+1:2] and commit writes at the RESP clock edge.
REQ-024 SHALL write byte lane addr[1:0] for a byte write, lanes {addr[1],0}..+1 for a half write (addr[0] ignored), and all lanes for a word write (addr[1:0] ignored).
REQ-025 SHALL return the read word shifted right by 8*addr[1:0], zero-filled, so the addressed byte or half is in bits [7:0] or [15:0].
REQ-026 SHALL read the memory at the end of WAIT so that a read issued right after a write to the same word sees the new data.

Reset
REQ-027 SHALL, while i_rst=1, force IDLE, counter 0, and o_wr_ready=o_rd_valid=o_busy=o_err=0 and o_data=0, independent of i_clk.
REQ-028 SHALL discard any pending write on reset mid-operation; memory contents are not cleared by reset and are zero at time 0.

Configuration
REQ-029 SHALL, with MEM_RESP_BOUNDS_EN defined, treat addr >= 4*DEPTH as out of range: the response still pulses, o_err pulses with it, writes are dropped and read data is 0.
REQ-030 SHALL, without MEM_RESP_BOUNDS_EN, omit o_err and wrap addresses modulo 4*DEPTH.

Structure
REQ-031 SHALL place in shared package mem_pkg: the size encoding constants MEM_B/MEM_H/MEM_W and the state enum; `DATA_WIDTH comes from common.svh.
REQ-032 SHALL use one sub-module, mem_resp_ram: a single-port synchronous RAM with 4 byte-enables, DEPTH words.

Verification
REQ-033 SHALL check: LATENCY=2, word write 0xDEADBEEF to 0x10 -> o_wr_ready exactly 3 cycles after capture; word read of 0x10 -> o_data=0xDEADBEEF with o_rd_valid.
REQ-034 SHALL check: byte write 0xAB to 0x13, then byte read of 0x13 -> 0x000000AB; word read of 0x10 -> 0xABADBEEF.
REQ-035 SHALL check: half read of 0x12 on word 0xABADBEEF -> 0x0000ABAD; LATENCY=0 -> pulse on the cycle after capture.
REQ-036 SHALL check: i_wr_valid dropped in WAIT -> no pulse, memory unchanged; i_rst asserted mid-WAIT -> outputs 0 asynchronously and the state is IDLE.
REQ-037 SHALL check: both requests high in IDLE -> write served first, then read back-to-back; with MEM_RESP_BOUNDS_EN, read of 4*DEPTH -> o_err=1 and o_data=0.
